// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array RF sequencer, RF and PE grid.
package sa_pkg;

    localparam int SA_N     = 8;
    localparam int SA_IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_COMP  = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } rf_seq_state_t;

endpackage

// File: rtl/rf_seq_ctrl_if.sv
// Row-load handshake plus RF / PE-array drive between host shim, sequencer and array.
interface rf_seq_ctrl_if #(
    parameter int IDX_W = sa_pkg::SA_IDX_W
);
    logic             ld_valid;
    logic             ld_ready;
    logic             rf_en;
    logic             write;
    logic [IDX_W-1:0] idx;
    logic             pe_clr;
    logic             pe_en;

    modport master (
        output ld_valid,
        input  ld_ready, rf_en, write, idx, pe_clr, pe_en
    );

    modport slave (
        input  ld_valid,
        output ld_ready, rf_en, write, idx, pe_clr, pe_en
    );
endinterface

// File: rtl/rf_seq_cnt.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
module rf_seq_cnt #(
    parameter int W  = 4,
    parameter int TC = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TC));

endmodule

// File: rtl/rf_seq_ctrl.sv
// Sequencer for the systolic-array RF: row load, PE clear, skewed compute sweep, drain.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// LOAD    | accepting host rows, writing RF at idx = rows accepted
// CLR     | one-cycle PE accumulator clear
// COMP    | stepping idx 0..2N-2 through the skewed window
// DRAIN   | PE array advances DRAIN_CYC more cycles
// FIN     | one-cycle done pulse
module rf_seq_ctrl
    import sa_pkg::*;
#(
    parameter int N         = SA_N,
    parameter int IDX_W     = SA_IDX_W,
    parameter int DRAIN_CYC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    rf_seq_ctrl_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state
);

    localparam int LD_W = $clog2(N + 1);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);

    if (2 * N - 1 > 2 ** IDX_W) begin : g_bad_idx_w
        $error("rf_seq_ctrl: IDX_W too narrow for 2*N-1 compute steps");
    end
    if (DRAIN_CYC < 1) begin : g_bad_drain
        $error("rf_seq_ctrl: DRAIN_CYC must be at least 1");
    end

    rf_seq_state_t state_q, state_d;
    logic [LD_W-1:0]  load_cnt;
    logic [IDX_W-1:0] step_cnt;
    logic [DR_W-1:0]  drain_cnt;
    logic load_tc, step_tc, drain_tc;
    logic accept;
    logic write_q, pe_clr_q, pe_en_q, busy_q, done_q;

    assign accept = (state_q == S_LOAD) && bus.ld_valid && !abort;

    rf_seq_cnt #(.W(LD_W), .TC(N - 1)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != S_LOAD) || abort || (accept && load_tc)),
        .en    (accept),
        .cnt   (load_cnt),
        .tc    (load_tc)
    );

    rf_seq_cnt #(.W(IDX_W), .TC(2 * N - 2)) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != S_COMP) || abort || step_tc),
        .en    (state_q == S_COMP),
        .cnt   (step_cnt),
        .tc    (step_tc)
    );

    rf_seq_cnt #(.W(DR_W), .TC(DRAIN_CYC - 1)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != S_DRAIN) || abort || drain_tc),
        .en    (state_q == S_DRAIN),
        .cnt   (drain_cnt),
        .tc    (drain_tc)
    );

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && !abort)     state_d = S_LOAD;
                S_LOAD:  if (accept && load_tc)   state_d = S_CLR;
                S_CLR:                            state_d = S_COMP;
                S_COMP:  if (step_tc)             state_d = S_DRAIN;
                S_DRAIN: if (drain_tc)            state_d = S_FIN;
                S_FIN:                            state_d = S_IDLE;
                default:                          state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            pe_clr_q <= 1'b0;
            pe_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= (state_d == S_LOAD);
            pe_clr_q <= (state_d == S_CLR);
            pe_en_q  <= (state_d == S_COMP) || (state_d == S_DRAIN);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_FIN);
        end
    end

    always_comb begin
        bus.idx = '0;
        if (state_q == S_LOAD)      bus.idx = IDX_W'(load_cnt);
        else if (state_q == S_COMP) bus.idx = step_cnt;
    end

    assign bus.ld_ready = (state_q == S_LOAD);
    assign bus.rf_en    = !abort && (((state_q == S_LOAD) && bus.ld_valid) || (state_q == S_COMP));
    assign bus.write    = write_q;
    assign bus.pe_clr   = pe_clr_q;
    assign bus.pe_en    = pe_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_rf_seq_ctrl;
    import sa_pkg::*;

    localparam int N  = SA_N;
    localparam int IW = SA_IDX_W;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;
    logic [2:0] state;

    rf_seq_ctrl_if #(.IDX_W(IW)) bus ();

    rf_seq_ctrl #(.N(N), .IDX_W(IW), .DRAIN_CYC(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc = -1;
    int clr_cyc  = -1;
    logic drv_start = 1'b0, drv_abort = 1'b0, drv_valid = 1'b0;

    // Timeline model: mode 0 idle, 1 loading (m_nacc rows taken), 2 post-load (m_r cycles since last row).
    int m_mode = 0, m_nacc = 0, m_r = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {1'b0, state, busy, done, bus.pe_en, bus.pe_clr, bus.write, bus.rf_en, bus.ld_ready, bus.idx};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [2:0] st = '0;
        logic bz = 1'b0, dn = 1'b0, pen = 1'b0, pcl = 1'b0, wr = 1'b0, rfe = 1'b0, ldr = 1'b0;
        logic [4:0] ix = '0;
        if (m_mode == 1) begin
            st = 3'd1; bz = 1'b1; ldr = 1'b1; wr = 1'b1;
            ix = 5'(m_nacc);
            rfe = drv_valid && !drv_abort;
        end else if (m_mode == 2) begin
            bz = 1'b1;
            if (m_r == 1) begin
                st = 3'd2; pcl = 1'b1;
            end else if (m_r <= 2 * N) begin
                st = 3'd3; pen = 1'b1; rfe = !drv_abort;
                ix = 5'(m_r - 2);
            end else if (m_r <= 2 * N + D) begin
                st = 3'd4; pen = 1'b1;
            end else begin
                st = 3'd5; dn = 1'b1;
            end
        end
        return {1'b0, st, bz, dn, pen, pcl, wr, rfe, ldr, ix};
    endfunction

    task automatic model_step();
        if (drv_abort && m_mode != 0) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (drv_start && !drv_abort) begin m_mode = 1; m_nacc = 0; end
                1: if (drv_valid) begin
                       m_nacc++;
                       if (m_nacc == N) begin m_mode = 2; m_r = 1; end
                   end
                default: begin
                    m_r++;
                    if (m_r > 2 * N + D + 1) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        start = drv_start;
        abort = drv_abort;
        bus.ld_valid = drv_valid;
        #1;
        cyc++;
        chk(tag, 32'(dut_vec()), 32'(model_vec()));
        if (done === 1'b1) done_cyc = cyc;
        if (bus.pe_clr === 1'b1) clr_cyc = cyc;
        model_step();
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cyc;
        int n = 0;
        while (done_cyc == d0 && n < 200) begin
            cycle(tag);
            n++;
        end
        if (done_cyc == d0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic go_until(input string tag, input int r_target);
        int n = 0;
        while (!(m_mode == 2 && m_r == r_target) && n < 200) begin
            cycle(tag);
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs, cs2, prev_done, acc_cyc, i;
        int pat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 1};
        bus.ld_valid = 1'b0;
        #2;
        chk("reset_init", 32'(dut_vec()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle("idle_after_reset");

        // nominal run with ld_valid held high
        drv_valid = 1'b1; drv_start = 1'b1;
        cycle("nom_start"); cs = cyc;
        drv_start = 1'b0;
        wait_done("nom");
        chk("nom_done_lat", done_cyc - cs, 33);
        chk("nom_clr_lat", clr_cyc - cs, 9);

        // back-to-back: start in the cycle right after done
        prev_done = done_cyc;
        drv_start = 1'b1;
        cycle("b2b_start"); cs2 = cyc;
        drv_start = 1'b0;
        chk("b2b_gap", cs2 - prev_done, 1);
        wait_done("b2b");
        chk("b2b_done_lat", done_cyc - cs2, 33);
        chk("b2b_clr_lat", clr_cyc - cs2, 9);

        // backpressure gaps
        drv_valid = 1'b0; drv_start = 1'b1;
        cycle("bp_start");
        drv_start = 1'b0;
        i = 0; acc_cyc = -1;
        while (m_mode == 1 && i < 100) begin
            drv_valid = pat[i % 12] != 0;
            cycle("bp_load");
            if (m_mode == 2) acc_cyc = cyc;
            i++;
        end
        drv_valid = 1'b0;
        wait_done("bp");
        chk("bp_clr_after_last", clr_cyc - acc_cyc, 1);

        // abort at compute idx 5, then restart
        drv_valid = 1'b1; drv_start = 1'b1;
        cycle("ab_start");
        drv_start = 1'b0;
        go_until("ab_run", 7);
        prev_done = done_cyc;
        drv_abort = 1'b1;
        cycle("ab_cycle");
        chk("ab_idx_at_abort", 32'(bus.idx), 5);
        drv_abort = 1'b0;
        cycle("ab_after");
        chk("ab_state", 32'(state), 0);
        chk("ab_pe_en_busy", {bus.rf_en, bus.pe_en, busy}, 0);
        repeat (4) cycle("ab_idle");
        chk("ab_no_done", done_cyc, prev_done);
        drv_start = 1'b1;
        cycle("ab_restart");
        drv_start = 1'b0;
        cycle("ab_reload");
        chk("ab_reload_idx", 32'(bus.idx), 0);
        wait_done("ab_rerun");

        // start during drain is ignored
        drv_start = 1'b1;
        cycle("dr_start"); cs = cyc;
        drv_start = 1'b0;
        go_until("dr_run", 2 * N + 2);
        drv_start = 1'b1;
        repeat (3) cycle("dr_start_in_drain");
        drv_start = 1'b0;
        wait_done("dr");
        chk("dr_done_lat", done_cyc - cs, 33);

        // start and abort together in idle
        cycle("sa_pre");
        drv_start = 1'b1; drv_abort = 1'b1;
        cycle("sa_both");
        drv_start = 1'b0; drv_abort = 1'b0;
        cycle("sa_after");
        chk("sa_state", 32'(state), 0);

        // reset mid-compute at idx 6
        drv_start = 1'b1;
        cycle("rst_start");
        drv_start = 1'b0;
        go_until("rst_run", 8);
        @(negedge clk);
        #1;
        chk("rst_pre_idx", 32'(bus.idx), 6);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_comp", 32'(dut_vec()), 0);
        m_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_done = done_cyc;
        repeat (5) cycle("rst_idle");
        chk("rst_no_done", done_cyc, prev_done);

        // random traffic
        repeat (1500) begin
            drv_start = ($urandom % 6) == 0;
            drv_abort = ($urandom % 60) == 0;
            drv_valid = ($urandom % 3) != 0;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
